// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - Relation codes, flag indices and relation decode shared by the comparator slice
package comparator_pkg;

    // Relation select codes carried on the mode input
    typedef enum logic [2:0] {
        MODE_EQ = 3'd0,
        MODE_NE = 3'd1,
        MODE_LT = 3'd2,
        MODE_LE = 3'd3,
        MODE_GT = 3'd4,
        MODE_GE = 3'd5
    } mode_e;

    // Codes 6 and 7 are unassigned; they always yield a false relation
    localparam logic [2:0] MODE_RSVD6 = 3'd6;
    localparam logic [2:0] MODE_RSVD7 = 3'd7;

    // Bit positions inside the {gt, eq, lt} flag vector
    localparam int FLAG_LT = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_GT = 2;
    localparam int FLAG_W  = 3;

    // Reduce the one-hot compare outcome to the selected relation
    function automatic logic relation_bit(
        input logic [2:0] mode_code,
        input logic       lt,
        input logic       eq,
        input logic       gt
    );
        logic rel;
        rel = 1'b0;
        case (mode_code)
            MODE_EQ: rel = eq;
            MODE_NE: rel = ~eq;
            MODE_LT: rel = lt;
            MODE_LE: rel = lt | eq;
            MODE_GT: rel = gt;
            MODE_GE: rel = gt | eq;
            default: rel = 1'b0;
        endcase
        return rel;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// rtl/comparator_core.sv - Combinational A-vs-B classifier; COMPARATOR_SIGNED_EN selects two's-complement operands
module comparator_core
    import comparator_pkg::*;
#(
    parameter int OW = 2
) (
    input  logic [OW-1:0] i_a,
    input  logic [OW-1:0] i_b,
    output logic          o_lt,
    output logic          o_eq,
    output logic          o_gt
);

    logic w_lt;
    logic w_eq;
    logic w_gt;

    // Equality is sign-agnostic; only the ordering depends on the operand interpretation
    always_comb begin
        w_eq = (i_a == i_b);
`ifdef COMPARATOR_SIGNED_EN
        w_lt = ($signed(i_a) < $signed(i_b));
`else
        w_lt = (i_a < i_b);
`endif
        w_gt = ~w_lt & ~w_eq;
    end

    assign o_lt = w_lt;
    assign o_eq = w_eq;
    assign o_gt = w_gt;

endmodule

// File: rtl/comparator.sv
// rtl/comparator.sv - Registered relation comparator over a packed operand pair; optional COMPARATOR_SIGNED_EN
module comparator
    import comparator_pkg::*;
#(
    parameter int    WIDTH        = 4,
    parameter mode_e DEFAULT_MODE = MODE_GT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    input  logic             mode_sel_en,
    input  logic [2:0]       mode,
    output logic             b,
    output logic [2:0]       flags,
    output logic             out_valid
);

    localparam int OW = WIDTH / 2;

    logic [OW-1:0]     w_op_a;
    logic [OW-1:0]     w_op_b;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;
    logic [2:0]        w_eff_mode;
    logic [FLAG_W-1:0] w_flags;
    logic              w_rel;

    logic              r_b;
    logic [FLAG_W-1:0] r_flags;
    logic              r_valid;

    // Upper half is A, lower half is B
    assign w_op_a = a[WIDTH-1:OW];
    assign w_op_b = a[OW-1:0];

    comparator_core #(
        .OW (OW)
    ) u_core (
        .i_a  (w_op_a),
        .i_b  (w_op_b),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    // Resolve the active relation and pack the flags by their named indices
    always_comb begin
        w_eff_mode       = mode_sel_en ? mode : DEFAULT_MODE;
        w_flags          = '0;
        w_flags[FLAG_LT] = w_lt;
        w_flags[FLAG_EQ] = w_eq;
        w_flags[FLAG_GT] = w_gt;
        w_rel            = relation_bit(w_eff_mode, w_lt, w_eq, w_gt);
    end

    // Capture a result on each valid sample; idle cycles only drop the valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b     <= 1'b0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_b     <= w_rel;
            r_flags <= w_flags;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign b         = r_b;
    assign flags     = r_flags;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - Directed self-checking bench for comparator with a cycle-level reference model
module tb_comparator;

    localparam int WIDTH = 4;
    localparam int OW    = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic             in_valid = 1'b0;
    logic             mode_sel_en = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic             b;
    logic [2:0]       flags;
    logic             out_valid;

    int checks = 0;
    int errors = 0;

    logic       m_b = 1'b0;
    logic [2:0] m_flags = 3'b000;
    logic       m_valid = 1'b0;

    comparator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .in_valid    (in_valid),
        .mode_sel_en (mode_sel_en),
        .mode        (mode),
        .b           (b),
        .flags       (flags),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    // Returns {relation, gt, eq, lt} from integer arithmetic on the operands
    function automatic logic [3:0] model_eval(input logic [WIDTH-1:0] av, input logic sel, input logic [2:0] md);
        int ai;
        int bi;
        int m;
        logic r;
        ai = int'(av[WIDTH-1:OW]);
        bi = int'(av[OW-1:0]);
`ifdef COMPARATOR_SIGNED_EN
        if (ai >= (1 << (OW - 1))) ai = ai - (1 << OW);
        if (bi >= (1 << (OW - 1))) bi = bi - (1 << OW);
`endif
        m = sel ? int'(md) : 4;
        case (m)
            0: r = (ai == bi);
            1: r = (ai != bi);
            2: r = (ai < bi);
            3: r = (ai <= bi);
            4: r = (ai > bi);
            5: r = (ai >= bi);
            default: r = 1'b0;
        endcase
        return {r, (ai > bi), (ai == bi), (ai < bi)};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference state: one-cycle registered view of the model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b     <= 1'b0;
            m_flags <= 3'b000;
            m_valid <= 1'b0;
        end else if (in_valid) begin
            {m_b, m_flags} <= model_eval(a, mode_sel_en, mode);
            m_valid        <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_out_valid", 8'(out_valid), 8'(m_valid));
        check("cyc_b", 8'(b), 8'(m_b));
        check("cyc_flags", 8'(flags), 8'(m_flags));
    end

    task automatic drive(input logic [WIDTH-1:0] av, input logic iv, input logic sel, input logic [2:0] md);
        a           = av;
        in_valid    = iv;
        mode_sel_en = sel;
        mode        = md;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] gt_mask;
    logic [7:0]  mode_exp;
    logic        exp_bit;

    initial begin
        // Pin the model to hand-derived values
        check("pin_0101_ge", 8'(model_eval(4'b0101, 1'b1, 3'd5)), 8'h0A);
        check("pin_0000_rsvd7", 8'(model_eval(4'b0000, 1'b1, 3'd7)), 8'h02);
`ifdef COMPARATOR_SIGNED_EN
        check("pin_1100_gt", 8'(model_eval(4'b1100, 1'b0, 3'd0)), 8'h01);
        gt_mask = 16'h40DC;
`else
        check("pin_1100_gt", 8'(model_eval(4'b1100, 1'b0, 3'd0)), 8'h0C);
        gt_mask = 16'h7310;
`endif

        // Reset held with a live sample on the inputs
        a = 4'b1001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_b", 8'(b), 8'h0);
        check("rst_flags", 8'(flags), 8'h0);
        check("rst_valid", 8'(out_valid), 8'h0);
        @(posedge clk);
        #1;
        check("rst_valid_2", 8'(out_valid), 8'h0);
        rst_n = 1'b1;
        drive(4'b1001, 1'b1, 1'b0, 3'd0);
        check("first_valid", 8'(out_valid), 8'h1);
`ifdef COMPARATOR_SIGNED_EN
        check("first_b", 8'(b), 8'h0);
        check("first_flags", 8'(flags), 8'h1);
`else
        check("first_b", 8'(b), 8'h1);
        check("first_flags", 8'(flags), 8'h4);
`endif

        // Exhaustive sweep in default GT mode
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 1'b1, 1'b0, 3'd0);
            check($sformatf("sweep_b_%0d", i), 8'(b), 8'(gt_mask[i]));
            check($sformatf("sweep_valid_%0d", i), 8'(out_valid), 8'h1);
        end

        // Every relation code on A == B
        mode_exp = 8'b0010_1001;
        for (int m = 0; m < 8; m++) begin
            drive(4'b0101, 1'b1, 1'b1, 3'(m));
            check($sformatf("mode_b_%0d", m), 8'(b), 8'(mode_exp[m]));
            check($sformatf("mode_flags_%0d", m), 8'(flags), 8'h2);
        end

        // mode is ignored when the select enable is low
        drive(4'b0101, 1'b1, 1'b0, 3'd0);
        check("default_eq_ignored", 8'(b), 8'h0);

        // Extreme operands
        drive(4'b1100, 1'b1, 1'b0, 3'd0);
`ifdef COMPARATOR_SIGNED_EN
        check("amax_flags", 8'(flags), 8'h1);
`else
        check("amax_flags", 8'(flags), 8'h4);
`endif
        drive(4'b0011, 1'b1, 1'b0, 3'd0);
`ifdef COMPARATOR_SIGNED_EN
        check("bmax_flags", 8'(flags), 8'h4);
`else
        check("bmax_flags", 8'(flags), 8'h1);
`endif

`ifdef COMPARATOR_SIGNED_EN
        drive(4'b1001, 1'b1, 1'b0, 3'd0);
        check("signed_1001_b", 8'(b), 8'h0);
        check("signed_1001_flags", 8'(flags), 8'h1);
        drive(4'b0110, 1'b1, 1'b0, 3'd0);
        check("signed_0110_b", 8'(b), 8'h1);
        check("signed_0110_flags", 8'(flags), 8'h4);
        exp_bit = 1'b0;
`else
        exp_bit = 1'b1;
`endif

        // Valid gating: outputs hold once the sample stream stops
        drive(4'b1000, 1'b1, 1'b0, 3'd0);
        check("gate_valid_on", 8'(out_valid), 8'h1);
        check("gate_b_on", 8'(b), 8'(exp_bit));
        drive(4'b0011, 1'b0, 1'b0, 3'd0);
        check("gate_valid_off", 8'(out_valid), 8'h0);
        check("gate_b_hold", 8'(b), 8'(exp_bit));
        drive(4'b0011, 1'b0, 1'b0, 3'd0);
        check("gate_b_hold_2", 8'(b), 8'(exp_bit));

        // Asynchronous reset between edges
        drive(4'b0100, 1'b1, 1'b0, 3'd0);
        check("pre_async_valid", 8'(out_valid), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_b", 8'(b), 8'h0);
        check("async_flags", 8'(flags), 8'h0);
        check("async_valid", 8'(out_valid), 8'h0);
        @(posedge clk);
        #1;
        check("async_hold_valid", 8'(out_valid), 8'h0);
        rst_n = 1'b1;
        drive(4'b0100, 1'b1, 1'b0, 3'd0);
        check("post_async_b", 8'(b), 8'h1);
        check("post_async_flags", 8'(flags), 8'h4);
        drive(4'b0000, 1'b0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
- Registered magnitude/equality comparator.
- One packed input vector `a` is split into two equal-width operands: A is the upper half, B is the lower half.
- Produces a single-bit relation result `b` for a run-time selectable relation, plus a one-hot lt/eq/gt flag vector.
- Leaf utility block used wherever a packed operand pair must be classified. Default configuration is a 4-bit input, i.e. two 2-bit operands.

Parameters:
- WIDTH, 4, total input width; must be even and >= 2. Operand width OW = WIDTH/2.
- DEFAULT_MODE, MODE_GT, relation applied while `mode_sel_en` = 0.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  packed operands: A = a[WIDTH-1:OW], B = a[OW-1:0].
- in_valid  input  1  `a` and `mode` sampled this cycle.
- mode_sel_en  input  1  1 = use `mode`, 0 = use DEFAULT_MODE.
- mode  input  3  relation select: EQ=0, NE=1, LT=2, LE=3, GT=4, GE=5; codes 6 and 7 are reserved.
- b  output  1  registered relation result.
- flags  output  3  registered {gt, eq, lt}, one-hot when valid.
- out_valid  output  1  `b` and `flags` are valid.

Behaviour:
- Reset (asynchronous assert, synchronous release): b=0, flags=3'b000, out_valid=0. Reset mid-operation discards any in-flight result.
- Latency is 1 cycle. A sample with in_valid=1 at edge N appears on b/flags with out_valid=1 after edge N. There is no backpressure; a new sample may be taken every cycle.
- If in_valid=0 at an edge: out_valid goes to 0, and b and flags hold their previous values.
- Core compare of A against B, exactly one flag set: lt = A<B, eq = A==B, gt = A>B.
- Relation results:
  - EQ = eq
  - NE = !eq
  - LT = lt
  - LE = lt|eq
  - GT = gt
  - GE = gt|eq
- Reserved mode codes 6 and 7 give b=0; flags are still computed normally.
- Effective mode = mode_sel_en ? mode : DEFAULT_MODE, sampled on the same edge as `a`.
- Comparison is unsigned by default (see Optional Feature).
- Boundaries: all-zeros input gives eq (b=0 in GT mode). A at its maximum and B=0 gives gt. A=0 and B at its maximum gives lt.
- No X propagation: outputs are fully defined whenever in_valid=1.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- Defined: A and B are treated as OW-bit two's-complement numbers. For OW=2 the range is -2..1.
- Undefined: A and B are unsigned, range 0..2^OW-1.
- Equality behaviour is identical in both builds.

Decomposition:
- Package comparator_pkg holds:
  - the mode enum (MODE_EQ..MODE_GE) and reserved-code constants;
  - flag bit-index constants FLAG_LT=0, FLAG_EQ=1, FLAG_GT=2.
- One combinational sub-module, comparator_core:
  - inputs: A and B (OW bits each);
  - outputs: lt, eq, gt;
  - contains the signed/unsigned selection under the macro.
- The top level adds mode decode and the output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and a=4'b1001, then release → b=0, flags=000 and out_valid=0 throughout reset; first sampled result appears 1 cycle after release.
- Exhaustive sweep in default GT mode (unsigned): a=0000..1111, one per cycle → b=1 only for a ∈ {0100,1000,1001,1100,1101,1110}; flags match the lt/eq/gt table.
- Mode sweep with a=4'b0101 (A=1, B=1) → EQ=1, NE=0, LT=0, LE=1, GT=0, GE=1. Reserved modes 6 and 7 → b=0 with flags=010.
- Signed build (COMPARATOR_SIGNED_EN), GT mode: a=4'b1001 (A=-2, B=1) → b=0, flags=001. a=4'b0110 (A=1, B=-2) → b=1, flags=100.
- Valid gating: in_valid=1 with a=1000, then in_valid=0 with a=0011 → out_valid=1 then 0; b stays 1 after out_valid drops.
- Asynchronous reset asserted mid-stream between clock edges → outputs clear immediately, without waiting for a clock edge.
